// File: rtl/frame_buffer_if.sv
// -----------------------------------------------------------------------------
// frame_buffer_if: write/read bus bundle for frame_buffer.
//   Parameters: IMG_W, IMG_H (frame size in pixels), PIX_W (pixel width).
//   XW/YW are the coordinate widths, clog2 of the frame size with a floor of 1.
//   Write side : wr_valid, wr_sof, wr_data (to buffer); wr_busy, frame_done (from buffer)
//   Read side  : rd_req, rd_x, rd_y (to buffer); rd_valid, rd_data, rd_oob (from buffer)
//   master = pixel source / read client, slave = frame_buffer.
// -----------------------------------------------------------------------------
interface frame_buffer_if #(
    parameter int unsigned IMG_W = 100,
    parameter int unsigned IMG_H = 100,
    parameter int unsigned PIX_W = 24
);
    localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic             wr_valid;
    logic             wr_sof;
    logic [PIX_W-1:0] wr_data;
    logic             wr_busy;
    logic             frame_done;
    logic             rd_req;
    logic [XW-1:0]    rd_x;
    logic [YW-1:0]    rd_y;
    logic             rd_valid;
    logic [PIX_W-1:0] rd_data;
    logic             rd_oob;

    modport master (
        output wr_valid, wr_sof, wr_data, rd_req, rd_x, rd_y,
        input  wr_busy, frame_done, rd_valid, rd_data, rd_oob
    );

    modport slave (
        input  wr_valid, wr_sof, wr_data, rd_req, rd_x, rd_y,
        output wr_busy, frame_done, rd_valid, rd_data, rd_oob
    );
endinterface

// File: rtl/frame_buffer.sv
// -----------------------------------------------------------------------------
// frame_buffer: raster-order pixel frame store with random-access reads.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; storage contents are kept
//   bus   : frame_buffer_if.slave
//           write side - sof pixel lands at (0,0), following pixels fill raster
//                        order; frame_done pulses one cycle after the last pixel
//           read side  - one-cycle latency, full throughput; out-of-range
//                        coordinates return data 0 with rd_oob set
// Build option: FRAME_BUFFER_DOUBLE_BUFFER_EN selects two banks; writer fills
//   bank bnk, reader sees bank ~bnk, bnk flips when a frame completes.
//   Undefined: one bank, reads observe the frame being written (read-before-write).
// -----------------------------------------------------------------------------
module frame_buffer #(
    parameter int unsigned IMG_W = 100,
    parameter int unsigned IMG_H = 100,
    parameter int unsigned PIX_W = 24
) (
    input  logic          clk,
    input  logic          reset,
    frame_buffer_if.slave bus
);
    localparam int unsigned XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned DEPTH = IMG_W * IMG_H;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef FRAME_BUFFER_DOUBLE_BUFFER_EN
    localparam int unsigned NB    = 2;
`else
    localparam int unsigned NB    = 1;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } wr_state_e;

    wr_state_e        state_q, state_d;
    logic [XW-1:0]    wx_q, wx_d;
    logic [YW-1:0]    wy_q, wy_d;
    logic             frame_done_q;
    logic             wr_busy_q;
    logic             wr_en_c;
    logic             done_c;
    logic [AW-1:0]    wr_addr_c;
    logic             wx_last_c;
    logic             wy_last_c;
    logic [0:0]       wr_bank_c;
    logic [0:0]       rd_bank_c;
    logic             rd_oob_c;
    logic [AW-1:0]    rd_addr_c;
    logic             rd_valid_q;
    logic             rd_oob_q;
    logic [PIX_W-1:0] rd_data_q;

    logic [PIX_W-1:0] mem [NB][DEPTH];

    assign wx_last_c = (wx_q == XW'(IMG_W - 1));
    assign wy_last_c = (wy_q == YW'(IMG_H - 1));

    // Writer next-state: sof restarts from any state, plain pixels only count in FILL
    always_comb begin
        state_d   = state_q;
        wx_d      = wx_q;
        wy_d      = wy_q;
        wr_en_c   = 1'b0;
        wr_addr_c = '0;
        done_c    = 1'b0;
        if (bus.wr_valid) begin
            if (bus.wr_sof) begin
                wr_en_c   = 1'b1;
                wr_addr_c = '0;
                if (IMG_W == 1 && IMG_H == 1) begin
                    // Single-pixel frame completes on the sof pixel
                    done_c  = 1'b1;
                    state_d = IDLE;
                    wx_d    = '0;
                    wy_d    = '0;
                end else if (IMG_W == 1) begin
                    state_d = FILL;
                    wx_d    = '0;
                    wy_d    = YW'(1);
                end else begin
                    state_d = FILL;
                    wx_d    = XW'(1);
                    wy_d    = '0;
                end
            end else if (state_q == FILL) begin
                wr_en_c   = 1'b1;
                wr_addr_c = AW'(wy_q) * AW'(IMG_W) + AW'(wx_q);
                if (wx_last_c && wy_last_c) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                    wx_d    = '0;
                    wy_d    = '0;
                end else if (wx_last_c) begin
                    wx_d = '0;
                    wy_d = wy_q + YW'(1);
                end else begin
                    wx_d = wx_q + XW'(1);
                end
            end
        end
    end

    // Writer state register and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wx_q         <= '0;
            wy_q         <= '0;
            frame_done_q <= 1'b0;
            wr_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wx_q         <= wx_d;
            wy_q         <= wy_d;
            frame_done_q <= done_c;
            wr_busy_q    <= (state_d == FILL);
        end
    end

`ifdef FRAME_BUFFER_DOUBLE_BUFFER_EN
    logic bnk_q;

    // Bank flips with frame completion; a read on that edge still sees the old bank
    always_ff @(posedge clk) begin
        if (reset) begin
            bnk_q <= 1'b0;
        end else if (done_c) begin
            bnk_q <= ~bnk_q;
        end
    end

    assign wr_bank_c = bnk_q;
    assign rd_bank_c = ~bnk_q;
`else
    assign wr_bank_c = 1'b0;
    assign rd_bank_c = 1'b0;
`endif

    // Pixel storage, not reset; a write during reset is dropped
    always_ff @(posedge clk) begin
        if (!reset && wr_en_c) begin
            mem[wr_bank_c][wr_addr_c] <= bus.wr_data;
        end
    end

    assign rd_oob_c  = (32'(bus.rd_x) >= IMG_W) || (32'(bus.rd_y) >= IMG_H);
    assign rd_addr_c = AW'(bus.rd_y) * AW'(IMG_W) + AW'(bus.rd_x);

    // Read port: one-cycle latency, data/oob hold between requests
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_req;
            if (bus.rd_req) begin
                if (rd_oob_c) begin
                    rd_data_q <= '0;
                    rd_oob_q  <= 1'b1;
                end else begin
                    rd_data_q <= mem[rd_bank_c][rd_addr_c];
                    rd_oob_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.wr_busy    = wr_busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_oob     = rd_oob_q;

endmodule

// File: tb/tb_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer: directed self-checking bench for frame_buffer.
//   fa/u_dut : 4x2 frame, main write/read scenarios
//   fb/u_oob : 3x3 frame, where out-of-range coordinates are representable
//   fc/u_one : 1x1 frame, sof pixel completes the frame
// With FRAME_BUFFER_DOUBLE_BUFFER_EN the bank-swap scenario replaces the
// single-bank read-while-writing checks.
// -----------------------------------------------------------------------------
module tb_frame_buffer;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt;

    always #5 clk = ~clk;

    frame_buffer_if #(.IMG_W(4), .IMG_H(2), .PIX_W(24)) fa ();
    frame_buffer_if #(.IMG_W(3), .IMG_H(3), .PIX_W(24)) fb ();
    frame_buffer_if #(.IMG_W(1), .IMG_H(1), .PIX_W(8))  fc ();

    frame_buffer #(.IMG_W(4), .IMG_H(2), .PIX_W(24)) u_dut (.clk(clk), .reset(reset), .bus(fa));
    frame_buffer #(.IMG_W(3), .IMG_H(3), .PIX_W(24)) u_oob (.clk(clk), .reset(reset), .bus(fb));
    frame_buffer #(.IMG_W(1), .IMG_H(1), .PIX_W(8))  u_one (.clk(clk), .reset(reset), .bus(fc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_wr(input logic sof, input logic [23:0] d);
        fa.wr_valid = 1'b1;
        fa.wr_sof   = sof;
        fa.wr_data  = d;
    endtask

    task automatic a_rd(input logic [1:0] x, input logic [0:0] y);
        fa.rd_req = 1'b1;
        fa.rd_x   = x;
        fa.rd_y   = y;
    endtask

    task automatic a_clr();
        fa.wr_valid = 1'b0;
        fa.wr_sof   = 1'b0;
        fa.rd_req   = 1'b0;
    endtask

    task automatic b_rd(input logic [1:0] x, input logic [1:0] y);
        fb.rd_req = 1'b1;
        fb.rd_x   = x;
        fb.rd_y   = y;
    endtask

    initial begin
        reset = 1'b1;
        a_clr();
        fa.wr_data = '0; fa.rd_x = '0; fa.rd_y = '0;
        fb.wr_valid = 1'b0; fb.wr_sof = 1'b0; fb.wr_data = '0;
        fb.rd_req = 1'b0; fb.rd_x = '0; fb.rd_y = '0;
        fc.wr_valid = 1'b0; fc.wr_sof = 1'b0; fc.wr_data = '0;
        fc.rd_req = 1'b0; fc.rd_x = '0; fc.rd_y = '0;

        // Reset state
        tick();
        tick();
        chk("rst_wr_busy", fa.wr_busy, 0);
        chk("rst_frame_done", fa.frame_done, 0);
        chk("rst_rd_valid", fa.rd_valid, 0);
        chk("rst_rd_data", fa.rd_data, 0);
        chk("rst_rd_oob", fa.rd_oob, 0);
        reset = 1'b0;

`ifndef FRAME_BUFFER_DOUBLE_BUFFER_EN
        // Full 4x2 frame, pixels 1..8
        a_wr(1'b1, 24'h000001); tick();
        chk("sof_busy", fa.wr_busy, 1);
        chk("sof_no_done", fa.frame_done, 0);
        for (int i = 2; i <= 7; i++) begin
            a_wr(1'b0, 24'(i)); tick();
            chk("mid_no_done", fa.frame_done, 0);
        end
        a_wr(1'b0, 24'h000008); tick();
        chk("last_done", fa.frame_done, 1);
        chk("last_busy_low", fa.wr_busy, 0);
        a_clr(); a_rd(2'd3, 1'b1); tick();
        chk("done_one_cycle", fa.frame_done, 0);
        chk("rd31_valid", fa.rd_valid, 1);
        chk("rd31_data", fa.rd_data, 24'h000008);
        chk("rd31_oob", fa.rd_oob, 0);
        a_rd(2'd0, 1'b0); tick();
        chk("rd00_data", fa.rd_data, 24'h000001);
        a_rd(2'd2, 1'b1); tick();
        chk("rd21_valid_b2b", fa.rd_valid, 1);
        chk("rd21_data", fa.rd_data, 24'h000007);
        a_clr(); tick();
        chk("rd_idle_valid", fa.rd_valid, 0);
        chk("rd_idle_hold", fa.rd_data, 24'h000007);

        // Same-cycle read and write at (1,0): old data returned
        a_wr(1'b1, 24'h000001); tick();
        a_wr(1'b0, 24'h000055); a_rd(2'd1, 1'b0); tick();
        chk("rbw_old_data", fa.rd_data, 24'h000002);
        a_clr(); a_rd(2'd1, 1'b0); tick();
        chk("rbw_new_data", fa.rd_data, 24'h000055);
        a_clr();
`else
        // Frame A all 0x11
        a_wr(1'b1, 24'h000011); tick();
        for (int i = 1; i <= 7; i++) begin
            a_wr(1'b0, 24'h000011); tick();
        end
        chk("dbA_done", fa.frame_done, 1);
        // Frame B all 0x22 while reading A
        a_wr(1'b1, 24'h000022); a_rd(2'd0, 1'b0); tick();
        chk("dbB_sof_reads_A", fa.rd_data, 24'h000011);
        for (int i = 1; i <= 6; i++) begin
            a_wr(1'b0, 24'h000022); a_rd(2'(i % 4), 1'(i / 4)); tick();
            chk("dbB_reads_A", fa.rd_data, 24'h000011);
        end
        a_wr(1'b0, 24'h000022); a_rd(2'd3, 1'b1); tick();
        chk("db_toggle_edge_read", fa.rd_data, 24'h000011);
        chk("dbB_done", fa.frame_done, 1);
        a_clr(); a_rd(2'd3, 1'b1); tick();
        chk("db_after_B_31", fa.rd_data, 24'h000022);
        a_rd(2'd0, 1'b0); tick();
        chk("db_after_B_00", fa.rd_data, 24'h000022);
        a_clr();
`endif

        // Restart: 3 pixels, sof 0xAA, then complete the frame
        done_cnt = 0;
        a_wr(1'b1, 24'h000010); tick(); done_cnt += int'(fa.frame_done);
        a_wr(1'b0, 24'h000011); tick(); done_cnt += int'(fa.frame_done);
        a_wr(1'b0, 24'h000012); tick(); done_cnt += int'(fa.frame_done);
        a_wr(1'b1, 24'h0000AA); tick(); done_cnt += int'(fa.frame_done);
        chk("restart_busy", fa.wr_busy, 1);
        for (int i = 1; i <= 7; i++) begin
            a_wr(1'b0, 24'h0000B0 + 24'(i)); tick(); done_cnt += int'(fa.frame_done);
        end
        chk("restart_done", fa.frame_done, 1);
        a_clr(); a_rd(2'd0, 1'b0); tick(); done_cnt += int'(fa.frame_done);
        chk("restart_00", fa.rd_data, 24'h0000AA);
        a_rd(2'd3, 1'b1); tick(); done_cnt += int'(fa.frame_done);
        chk("restart_31", fa.rd_data, 24'h0000B7);
        a_clr(); tick(); done_cnt += int'(fa.frame_done);
        chk("restart_one_pulse", done_cnt, 1);

        // Reset mid-frame after 5 pixels, with a write and read on the reset edge
        done_cnt = 0;
        a_wr(1'b1, 24'h000020); tick();
        for (int i = 1; i <= 4; i++) begin
            a_wr(1'b0, 24'h000020 + 24'(i)); tick(); done_cnt += int'(fa.frame_done);
        end
        chk("pre_rst_busy", fa.wr_busy, 1);
        a_wr(1'b0, 24'h0000DD); a_rd(2'd3, 1'b1); reset = 1'b1; tick(); reset = 1'b0;
        done_cnt += int'(fa.frame_done);
        chk("midrst_busy", fa.wr_busy, 0);
        chk("midrst_rd_valid", fa.rd_valid, 0);
        chk("midrst_rd_data", fa.rd_data, 0);
        chk("midrst_rd_oob", fa.rd_oob, 0);
        for (int i = 0; i < 3; i++) begin
            a_wr(1'b0, 24'h0000EE); a_clr(); a_wr(1'b0, 24'h0000EE); tick();
            done_cnt += int'(fa.frame_done);
            chk("idle_ignore_busy", fa.wr_busy, 0);
        end
        a_clr(); tick(); done_cnt += int'(fa.frame_done);
        chk("midrst_no_done", done_cnt, 0);
`ifndef FRAME_BUFFER_DOUBLE_BUFFER_EN
        a_rd(2'd0, 1'b0); tick();
        chk("kept_00", fa.rd_data, 24'h000020);
        a_rd(2'd1, 1'b0); tick();
        chk("kept_10", fa.rd_data, 24'h000021);
        a_rd(2'd1, 1'b1); tick();
        chk("dropped_rst_write_11", fa.rd_data, 24'h0000B5);
        a_rd(2'd2, 1'b1); tick();
        chk("kept_21", fa.rd_data, 24'h0000B6);
        a_clr();
`endif

        // Out-of-range reads on a 3x3 frame
        fb.wr_valid = 1'b1; fb.wr_sof = 1'b1; fb.wr_data = 24'h000031; tick();
        fb.wr_sof = 1'b0;
        for (int i = 2; i <= 9; i++) begin
            fb.wr_data = 24'h000030 + 24'(i); tick();
        end
        chk("oobfr_done", fb.frame_done, 1);
        fb.wr_valid = 1'b0;
        b_rd(2'd0, 2'd0); tick();
        chk("oob_in00_data", fb.rd_data, 24'h000031);
        b_rd(2'd3, 2'd0); tick();
        chk("oob_x_valid", fb.rd_valid, 1);
        chk("oob_x_flag", fb.rd_oob, 1);
        chk("oob_x_data", fb.rd_data, 0);
        b_rd(2'd2, 2'd2); tick();
        chk("oob_in22_flag", fb.rd_oob, 0);
        chk("oob_in22_data", fb.rd_data, 24'h000039);
        b_rd(2'd0, 2'd3); tick();
        chk("oob_y_flag", fb.rd_oob, 1);
        chk("oob_y_data", fb.rd_data, 0);
        fb.rd_req = 1'b0;

        // 1x1 frame completes on the sof pixel
        fc.wr_valid = 1'b1; fc.wr_sof = 1'b1; fc.wr_data = 8'h5A; tick();
        chk("one_done", fc.frame_done, 1);
        chk("one_busy", fc.wr_busy, 0);
        fc.wr_valid = 1'b0; fc.wr_sof = 1'b0;
        fc.rd_req = 1'b1; tick();
        chk("one_done_drop", fc.frame_done, 0);
        chk("one_rd_data", fc.rd_data, 8'h5A);
        fc.rd_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
